// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the boot loader (port 0), the CPU
// (port 1), the memory controller and the mem_arbiter.
//   master modport : arbiter view. It takes requests and memory responses and
//                    drives the port responses, the memory request, grant and
//                    timeout_err.
//   slave modport  : environment view (requesters plus memory), the mirror of
//                    master.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          boot_done;

  logic          p0_request;
  logic          p0_mode;
  logic [AW-1:0] p0_locator;
  logic [DW-1:0] p0_write;
  logic          p0_response;
  logic [DW-1:0] p0_read;

  logic          p1_request;
  logic          p1_mode;
  logic [AW-1:0] p1_locator;
  logic [DW-1:0] p1_write;
  logic          p1_response;
  logic [DW-1:0] p1_read;

  logic          mem_request;
  logic          mem_mode;
  logic [AW-1:0] mem_locator;
  logic [DW-1:0] mem_write;
  logic [DW-1:0] mem_read;
  logic          mem_response;

  logic [1:0]    grant;
  logic          timeout_err;

  modport master (
    input  boot_done,
    input  p0_request, p0_mode, p0_locator, p0_write,
    output p0_response, p0_read,
    input  p1_request, p1_mode, p1_locator, p1_write,
    output p1_response, p1_read,
    output mem_request, mem_mode, mem_locator, mem_write,
    input  mem_read, mem_response,
    output grant, timeout_err
  );

  modport slave (
    output boot_done,
    output p0_request, p0_mode, p0_locator, p0_write,
    input  p0_response, p0_read,
    output p1_request, p1_mode, p1_locator, p1_write,
    input  p1_response, p1_read,
    input  mem_request, mem_mode, mem_locator, mem_write,
    output mem_read, mem_response,
    input  grant, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the boot loader (port 0) and the
// CPU (port 1). The CPU is held off until boot_done. After that the two ports
// are served round-robin. Each access runs a request/response handshake with
// the memory, and a hung access is aborted after TIMEOUT cycles.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mem_arbiter_if.master. It carries the port 0/1 request buses,
//                the memory request bus, grant and the sticky timeout_err.
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    HOLD    = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;       // 0 = port 0, 1 = port 1
  logic          last_q, last_d;         // port served most recently
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    grant_q, grant_d;
  logic          mem_request_q, mem_request_d;
  logic          mem_mode_q, mem_mode_d;
  logic [AW-1:0] mem_locator_q, mem_locator_d;
  logic [DW-1:0] mem_write_q, mem_write_d;
  logic          p0_response_q, p0_response_d;
  logic          p1_response_q, p1_response_d;
  logic [DW-1:0] p0_read_q, p0_read_d;
  logic [DW-1:0] p1_read_q, p1_read_d;
  logic          timeout_err_q, timeout_err_d;

  logic          p0_elig_c, p1_elig_c;
  logic          pick_c;
  logic          owner_req_c;

  assign p0_elig_c   = bus.p0_request;
  assign p1_elig_c   = bus.p1_request & bus.boot_done;
  assign owner_req_c = owner_q ? bus.p1_request : bus.p0_request;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      timer_q       <= '0;
      grant_q       <= 2'b00;
      mem_request_q <= 1'b0;
      mem_mode_q    <= 1'b0;
      mem_locator_q <= '0;
      mem_write_q   <= '0;
      p0_response_q <= 1'b0;
      p1_response_q <= 1'b0;
      p0_read_q     <= '0;
      p1_read_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      grant_q       <= grant_d;
      mem_request_q <= mem_request_d;
      mem_mode_q    <= mem_mode_d;
      mem_locator_q <= mem_locator_d;
      mem_write_q   <= mem_write_d;
      p0_response_q <= p0_response_d;
      p1_response_q <= p1_response_d;
      p0_read_q     <= p0_read_d;
      p1_read_q     <= p1_read_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    timer_d       = timer_q;
    grant_d       = grant_q;
    mem_request_d = mem_request_q;
    mem_mode_d    = mem_mode_q;
    mem_locator_d = mem_locator_q;
    mem_write_d   = mem_write_q;
    p0_response_d = 1'b0;
    p1_response_d = 1'b0;
    p0_read_d     = p0_read_q;
    p1_read_d     = p1_read_q;
    timeout_err_d = timeout_err_q;
    pick_c        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (p0_elig_c || p1_elig_c) begin
          // On a tie, the port that was not served last wins.
          pick_c        = (p0_elig_c && p1_elig_c) ? ~last_q : p1_elig_c;
          owner_d       = pick_c;
          grant_d       = pick_c ? 2'b10 : 2'b01;
          mem_request_d = 1'b1;
          mem_mode_d    = pick_c ? bus.p1_mode    : bus.p0_mode;
          mem_locator_d = pick_c ? bus.p1_locator : bus.p0_locator;
          mem_write_d   = pick_c ? bus.p1_write   : bus.p0_write;
          timer_d       = '0;
          state_d       = ISSUE;
        end
      end

      ISSUE, HOLD: begin
        timer_d = TW'(timer_q + 1'b1);
        if (state_q == HOLD && !bus.mem_response) begin
          // Normal completion on the falling edge of mem_response.
          mem_request_d = 1'b0;
          p0_response_d = ~owner_q;
          p1_response_d = owner_q;
          state_d       = ACK;
        end else if (timer_q == TIMER_LAST) begin
          // Abort. The timeout beats a late ISSUE response, so read data is untouched.
          mem_request_d = 1'b0;
          timeout_err_d = 1'b1;
          p0_response_d = ~owner_q;
          p1_response_d = owner_q;
          state_d       = ACK;
        end else if (state_q == ISSUE && bus.mem_response) begin
          if (owner_q) p1_read_d = bus.mem_read;
          else         p0_read_d = bus.mem_read;
          state_d = HOLD;
        end
      end

      ACK: begin
        state_d = RELEASE;
      end

      RELEASE: begin
        // The owner must drop its request before anyone can be granted again.
        if (!owner_req_c) begin
          grant_d = 2'b00;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.mem_request = mem_request_q;
  assign bus.mem_mode    = mem_mode_q;
  assign bus.mem_locator = mem_locator_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.p0_response = p0_response_q;
  assign bus.p1_response = p1_response_q;
  assign bus.p0_read     = p0_read_q;
  assign bus.p1_read     = p1_read_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with TIMEOUT=8. It covers the
// boot write, the boot gate, round-robin contention, a CPU read, a timeout
// abort and a reset in the middle of an access.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] exp_r0;
  logic [15:0] exp_r1;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle. Return 1 time unit after the edge so that checks and
  // new inputs both land away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Finish an access that is already in ISSUE: one cycle of mem_response
  // carrying rdata, then the response pulse, request drop and release.
  task automatic serve(input int port, input logic [15:0] rdata);
    bus.mem_read     = rdata;
    bus.mem_response = 1'b1;
    tick();
    check("hold_req", 32'(bus.mem_request), 32'd1);
    bus.mem_response = 1'b0;
    tick();
    if (port == 0) exp_r0 = rdata;
    else           exp_r1 = rdata;
    check("ack_req_low", 32'(bus.mem_request), 32'd0);
    check("p0_resp_pulse", 32'(bus.p0_response), (port == 0) ? 32'd1 : 32'd0);
    check("p1_resp_pulse", 32'(bus.p1_response), (port == 1) ? 32'd1 : 32'd0);
    check("p0_read_ack", 32'(bus.p0_read), 32'(exp_r0));
    check("p1_read_ack", 32'(bus.p1_read), 32'(exp_r1));
    if (port == 0) bus.p0_request = 1'b0;
    else           bus.p1_request = 1'b0;
    tick();
    check("p0_resp_one", 32'(bus.p0_response), 32'd0);
    check("p1_resp_one", 32'(bus.p1_response), 32'd0);
    tick();
    check("grant_idle", 32'(bus.grant), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_r0 = 16'h0000;
    exp_r1 = 16'h0000;
    rst_n = 1'b0;
    bus.boot_done    = 1'b0;
    bus.p0_request   = 1'b0;
    bus.p0_mode      = 1'b0;
    bus.p0_locator   = 16'h0000;
    bus.p0_write     = 16'h0000;
    bus.p1_request   = 1'b0;
    bus.p1_mode      = 1'b0;
    bus.p1_locator   = 16'h0000;
    bus.p1_write     = 16'h0000;
    bus.mem_read     = 16'h0000;
    bus.mem_response = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_mem_req", 32'(bus.mem_request), 32'd0);
    check("rst_p0_resp", 32'(bus.p0_response), 32'd0);
    check("rst_p1_resp", 32'(bus.p1_response), 32'd0);
    check("rst_tmo", 32'(bus.timeout_err), 32'd0);
    check("rst_p0_read", 32'(bus.p0_read), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. Boot write: p0 writes 0x2000 to addr 0, mem_response high for 2 cycles
    bus.p0_request = 1'b1;
    bus.p0_mode    = 1'b1;
    bus.p0_locator = 16'h0000;
    bus.p0_write   = 16'h2000;
    tick();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_mem_req", 32'(bus.mem_request), 32'd1);
    check("t1_loc", 32'(bus.mem_locator), 32'h0);
    check("t1_wdata", 32'(bus.mem_write), 32'h2000);
    check("t1_mode", 32'(bus.mem_mode), 32'd1);
    bus.mem_read     = 16'h0000;
    bus.mem_response = 1'b1;
    tick();
    tick();
    check("t1_hold_req", 32'(bus.mem_request), 32'd1);
    check("t1_no_early_resp", 32'(bus.p0_response), 32'd0);
    bus.mem_response = 1'b0;
    tick();
    check("t1_req_drop", 32'(bus.mem_request), 32'd0);
    check("t1_resp", 32'(bus.p0_response), 32'd1);
    check("t1_grant_ack", 32'(bus.grant), 32'h1);
    bus.p0_request = 1'b0;
    tick();
    check("t1_resp_one", 32'(bus.p0_response), 32'd0);
    tick();
    check("t1_grant_idle", 32'(bus.grant), 32'h0);

    // 2. Boot gate: p1 ignored while boot_done is low
    bus.p1_request = 1'b1;
    bus.p1_mode    = 1'b1;
    bus.p1_locator = 16'h0010;
    bus.p1_write   = 16'h1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t2_gate_grant", 32'(bus.grant), 32'h0);
      check("t2_gate_req", 32'(bus.mem_request), 32'd0);
    end
    bus.boot_done = 1'b1;
    tick();
    check("t2_grant", 32'(bus.grant), 32'h2);
    check("t2_loc", 32'(bus.mem_locator), 32'h0010);
    serve(1, 16'h0101);

    // 3. Contention: both ports requesting, grants alternate starting with p0
    bus.p0_request = 1'b1;
    bus.p1_request = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_grant", 32'(bus.grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      serve(k % 2, 16'(16'h3000 + k));
      if (k < 3) begin
        if (k % 2 == 0) bus.p0_request = 1'b1;
        else            bus.p1_request = 1'b1;
      end
    end
    bus.p0_request = 1'b0;
    tick();
    check("t3_idle", 32'(bus.grant), 32'h0);

    // 4. Read: p1 reads addr 0x0005, memory returns 0xBBBB
    bus.p1_request = 1'b1;
    bus.p1_mode    = 1'b0;
    bus.p1_locator = 16'h0005;
    tick();
    check("t4_grant", 32'(bus.grant), 32'h2);
    check("t4_loc", 32'(bus.mem_locator), 32'h0005);
    check("t4_mode", 32'(bus.mem_mode), 32'd0);
    serve(1, 16'hBBBB);
    check("t4_p1_read", 32'(bus.p1_read), 32'hBBBB);
    check("t4_p0_read", 32'(bus.p0_read), 32'h3002);

    // 5. Timeout: memory never answers, abort after 8 cycles of mem_request
    bus.mem_read   = 16'hDEAD;
    bus.p0_request = 1'b1;
    bus.p0_mode    = 1'b0;
    bus.p0_locator = 16'h0042;
    tick();
    check("t5_req", 32'(bus.mem_request), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t5_req_held", 32'(bus.mem_request), 32'd1);
      check("t5_tmo_low", 32'(bus.timeout_err), 32'd0);
    end
    tick();
    check("t5_req_drop", 32'(bus.mem_request), 32'd0);
    check("t5_resp", 32'(bus.p0_response), 32'd1);
    check("t5_tmo_set", 32'(bus.timeout_err), 32'd1);
    check("t5_read_kept", 32'(bus.p0_read), 32'(exp_r0));
    bus.p0_request = 1'b0;
    tick();
    tick();
    check("t5_grant_idle", 32'(bus.grant), 32'h0);
    check("t5_tmo_sticky", 32'(bus.timeout_err), 32'd1);

    // 6. Reset in HOLD, then a fresh p0 access
    bus.p0_request = 1'b1;
    bus.p0_mode    = 1'b1;
    bus.p0_locator = 16'h0077;
    bus.p0_write   = 16'h5555;
    tick();
    bus.mem_read     = 16'h9999;
    bus.mem_response = 1'b1;
    tick();
    check("t6_hold_req", 32'(bus.mem_request), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(bus.mem_request), 32'd0);
    check("t6_rst_grant", 32'(bus.grant), 32'h0);
    check("t6_rst_p0_resp", 32'(bus.p0_response), 32'd0);
    check("t6_rst_tmo", 32'(bus.timeout_err), 32'd0);
    check("t6_rst_read", 32'(bus.p0_read), 32'h0);
    exp_r0 = 16'h0000;
    exp_r1 = 16'h0000;
    bus.mem_response = 1'b0;
    tick();
    check("t6_rst_no_pulse", 32'(bus.p0_response), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t6_regrant", 32'(bus.grant), 32'h1);
    check("t6_loc", 32'(bus.mem_locator), 32'h0077);
    serve(0, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
